// File: rtl/wb_stage.sv
// Write-back stage: aligns MEM control with mem's registered data, formats loads,
// selects the write-back source, drives the regfile write port, two forwarding ports and instret.
module wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic             flush_i,
    input  logic             regWE_i,
    input  logic [4:0]       rd_i,
    input  logic [1:0]       wbSel_i,
    input  logic [1:0]       dataSec_i,
    input  logic             unsigned_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  data_i,
    input  logic [XLEN-1:0]  alu_i,
    output logic             regWE_o,
    output logic [4:0]       rd_o,
    output logic [XLEN-1:0]  wbData_o,
    output logic             fwd1V_o,
    output logic [4:0]       fwd1Rd_o,
    output logic [XLEN-1:0]  fwd1D_o,
    output logic             fwd2V_o,
    output logic [4:0]       fwd2Rd_o,
    output logic [XLEN-1:0]  fwd2D_o,
    output logic [CNT_W-1:0] instret_o
);

    logic             v_q, v_d;
    logic             regwe_q, regwe_d;
    logic [4:0]       rd_q, rd_d;
    logic [1:0]       wbsel_q, wbsel_d;
    logic [1:0]       datasec_q, datasec_d;
    logic             unsigned_q, unsigned_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             fwd2v_q, fwd2v_d;
    logic [4:0]       fwd2rd_q, fwd2rd_d;
    logic [XLEN-1:0]  fwd2d_q, fwd2d_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic             wr_en;
    logic [4:0]       wr_rd;
    logic [XLEN-1:0]  wr_data;
    logic [XLEN-1:0]  load_val;
    logic [XLEN-1:0]  src_val;

    // Load formatting is big-endian: the addressed byte/half sits in the top bits of data_i.
    always_comb begin
        load_val = data_i;
        case (datasec_q)
            2'b00: load_val = unsigned_q ? {{(XLEN-8){1'b0}}, data_i[XLEN-1 -: 8]}
                                         : {{(XLEN-8){data_i[XLEN-1]}}, data_i[XLEN-1 -: 8]};
            2'b01: load_val = unsigned_q ? {{(XLEN-16){1'b0}}, data_i[XLEN-1 -: 16]}
                                         : {{(XLEN-16){data_i[XLEN-1]}}, data_i[XLEN-1 -: 16]};
            default: load_val = data_i;
        endcase
    end

    always_comb begin
        src_val = '0;
        case (wbsel_q)
            2'b00:   src_val = alu_i;
            2'b01:   src_val = load_val;
            2'b10:   src_val = pc_q + XLEN'(4);
            default: src_val = '0;
        endcase
    end

    // Writes to x0 are suppressed here so neither the regfile nor the forwarding ports see them.
    always_comb begin
        wr_en   = v_q & regwe_q & (rd_q != 5'd0);
        wr_rd   = wr_en ? rd_q : 5'd0;
        wr_data = wr_en ? src_val : '0;
    end

    always_comb begin
        v_d        = valid_i & ~flush_i;
        regwe_d    = regWE_i;
        rd_d       = rd_i;
        wbsel_d    = wbSel_i;
        datasec_d  = dataSec_i;
        unsigned_d = unsigned_i;
        pc_d       = pc_i;
        fwd2v_d    = wr_en;
        fwd2rd_d   = wr_rd;
        fwd2d_d    = wr_data;
        instret_d  = instret_q + {{(CNT_W-1){1'b0}}, v_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q        <= 1'b0;
            regwe_q    <= 1'b0;
            rd_q       <= '0;
            wbsel_q    <= '0;
            datasec_q  <= '0;
            unsigned_q <= 1'b0;
            pc_q       <= '0;
            fwd2v_q    <= 1'b0;
            fwd2rd_q   <= '0;
            fwd2d_q    <= '0;
            instret_q  <= '0;
        end else begin
            v_q        <= v_d;
            regwe_q    <= regwe_d;
            rd_q       <= rd_d;
            wbsel_q    <= wbsel_d;
            datasec_q  <= datasec_d;
            unsigned_q <= unsigned_d;
            pc_q       <= pc_d;
            fwd2v_q    <= fwd2v_d;
            fwd2rd_q   <= fwd2rd_d;
            fwd2d_q    <= fwd2d_d;
            instret_q  <= instret_d;
        end
    end

    assign regWE_o   = wr_en;
    assign rd_o      = wr_rd;
    assign wbData_o  = wr_data;
    assign fwd1V_o   = wr_en;
    assign fwd1Rd_o  = wr_rd;
    assign fwd1D_o   = wr_data;
    assign fwd2V_o   = fwd2v_q;
    assign fwd2Rd_o  = fwd2rd_q;
    assign fwd2D_o   = fwd2d_q;
    assign instret_o = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed vectors push expected writes, a monitor pops and compares.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, flush_i, regWE_i, unsigned_i;
    logic [4:0]  rd_i;
    logic [1:0]  wbSel_i, dataSec_i;
    logic [31:0] pc_i, data_i, alu_i;
    logic        regWE_o, fwd1V_o, fwd2V_o;
    logic [4:0]  rd_o, fwd1Rd_o, fwd2Rd_o;
    logic [31:0] wbData_o, fwd1D_o, fwd2D_o;
    logic [63:0] instret_o;
    logic        smRegWE, smFwd1V, smFwd2V;
    logic [4:0]  smRd, smFwd1Rd, smFwd2Rd;
    logic [31:0] smWbData, smFwd1D, smFwd2D;
    logic [3:0]  smInstret;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        valid, flush, we;
        logic [4:0]  rd;
        logic [1:0]  sel, sec;
        logic        uns;
        logic [31:0] pc, data, alu, exp;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] pendData = 32'h0;
    logic [31:0] pendAlu  = 32'h0;

    always #5 clk = ~clk;

    wb_stage #(.XLEN(32), .CNT_W(64)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i), .regWE_i(regWE_i),
        .rd_i(rd_i), .wbSel_i(wbSel_i), .dataSec_i(dataSec_i), .unsigned_i(unsigned_i),
        .pc_i(pc_i), .data_i(data_i), .alu_i(alu_i),
        .regWE_o(regWE_o), .rd_o(rd_o), .wbData_o(wbData_o),
        .fwd1V_o(fwd1V_o), .fwd1Rd_o(fwd1Rd_o), .fwd1D_o(fwd1D_o),
        .fwd2V_o(fwd2V_o), .fwd2Rd_o(fwd2Rd_o), .fwd2D_o(fwd2D_o),
        .instret_o(instret_o)
    );

    // Narrow-counter copy sharing the same stimulus, so counter wrap is reachable in a few cycles.
    wb_stage #(.XLEN(32), .CNT_W(4)) dutSmall (
        .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i), .regWE_i(regWE_i),
        .rd_i(rd_i), .wbSel_i(wbSel_i), .dataSec_i(dataSec_i), .unsigned_i(unsigned_i),
        .pc_i(pc_i), .data_i(data_i), .alu_i(alu_i),
        .regWE_o(smRegWE), .rd_o(smRd), .wbData_o(smWbData),
        .fwd1V_o(smFwd1V), .fwd1Rd_o(smFwd1Rd), .fwd1D_o(smFwd1D),
        .fwd2V_o(smFwd2V), .fwd2Rd_o(smFwd2Rd), .fwd2D_o(smFwd2D),
        .instret_o(smInstret)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic f, input logic we, input logic [4:0] rd,
                                input logic [1:0] sel, input logic [1:0] sec, input logic uns,
                                input logic [31:0] pc, input logic [31:0] data,
                                input logic [31:0] alu, input logic [31:0] exp);
        vec_t t;
        t.valid = v; t.flush = f; t.we = we; t.rd = rd; t.sel = sel; t.sec = sec;
        t.uns = uns; t.pc = pc; t.data = data; t.alu = alu; t.exp = exp;
        return t;
    endfunction

    // Control for this vector goes out now; its data follows with the next call.
    task automatic applyStimulus(input vec_t t);
        exp_t e;
        @(negedge clk);
        valid_i    = t.valid;
        flush_i    = t.flush;
        regWE_i    = t.we;
        rd_i       = t.rd;
        wbSel_i    = t.sel;
        dataSec_i  = t.sec;
        unsigned_i = t.uns;
        pc_i       = t.pc;
        data_i     = pendData;
        alu_i      = pendAlu;
        pendData   = t.data;
        pendAlu    = t.alu;
        if (t.valid && !t.flush && t.we && t.rd != 5'd0) begin
            e.rd = t.rd;
            e.d  = t.exp;
            expQ.push_back(e);
        end
    endtask

    task automatic drain();
        applyStimulus(mk(0, 0, 0, 5'd0, 2'b00, 2'b00, 0, 32'h0, 32'h0, 32'h0, 32'h0));
        applyStimulus(mk(0, 0, 0, 5'd0, 2'b00, 2'b00, 0, 32'h0, 32'h0, 32'h0, 32'h0));
        #2;
    endtask

    task automatic setBubble();
        valid_i = 0; flush_i = 0; regWE_i = 0; rd_i = 0; wbSel_i = 0;
        dataSec_i = 0; unsigned_i = 0; pc_i = 0; data_i = 0; alu_i = 0;
    endtask

    // Monitor: pops one expected write whenever the DUT asserts regWE_o; fwd2 must echo last cycle's write.
    initial begin
        logic        lastV, curV;
        logic [4:0]  lastRd, curRd;
        logic [31:0] lastD, curD;
        exp_t        e;
        lastV = 0; lastRd = 0; lastD = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                lastV = 0; lastRd = 0; lastD = 0;
            end else begin
                curV = 0; curRd = 0; curD = 0;
                if (regWE_o) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_write: got rd=%0d data=%h expected no write",
                                 rd_o, wbData_o);
                    end else begin
                        e = expQ.pop_front();
                        curV = 1; curRd = e.rd; curD = e.d;
                    end
                end
                checkOutput("rd_o", rd_o, curRd);
                checkOutput("wbData_o", wbData_o, curD);
                checkOutput("fwd1V_o", fwd1V_o, curV);
                checkOutput("fwd1Rd_o", fwd1Rd_o, curRd);
                checkOutput("fwd1D_o", fwd1D_o, curD);
                checkOutput("fwd2V_o", fwd2V_o, lastV);
                checkOutput("fwd2Rd_o", fwd2Rd_o, lastRd);
                checkOutput("fwd2D_o", fwd2D_o, lastD);
                lastV = curV; lastRd = curRd; lastD = curD;
            end
        end
    end

    initial begin
        // Reset with a write-looking instruction and mem's reset data on the inputs.
        rst = 1;
        valid_i = 1; flush_i = 0; regWE_i = 1; rd_i = 5'd5; wbSel_i = 2'b01;
        dataSec_i = 2'b10; unsigned_i = 0; pc_i = 32'h100;
        data_i = 32'hFFFFFFFF; alu_i = 32'hFFFFFFFF;
        #12;
        checkOutput("reset_regWE", regWE_o, 0);
        checkOutput("reset_rd", rd_o, 0);
        checkOutput("reset_wbData", wbData_o, 0);
        checkOutput("reset_fwd2V", fwd2V_o, 0);
        checkOutput("reset_instret", instret_o, 0);
        #1;
        setBubble();
        rst = 0;

        applyStimulus(mk(1, 0, 1, 5'd5,  2'b01, 2'b00, 0, 32'h0, 32'h80123456, 32'h0, 32'hFFFFFF80));
        applyStimulus(mk(1, 0, 1, 5'd5,  2'b01, 2'b00, 1, 32'h0, 32'h80123456, 32'h0, 32'h00000080));
        applyStimulus(mk(1, 0, 1, 5'd5,  2'b01, 2'b00, 0, 32'h0, 32'h7F00FFFF, 32'h0, 32'h0000007F));
        applyStimulus(mk(1, 0, 1, 5'd6,  2'b01, 2'b01, 0, 32'h0, 32'h80011234, 32'h0, 32'hFFFF8001));
        applyStimulus(mk(1, 0, 1, 5'd6,  2'b01, 2'b01, 1, 32'h0, 32'h80011234, 32'h0, 32'h00008001));
        applyStimulus(mk(1, 0, 1, 5'd7,  2'b01, 2'b10, 0, 32'h0, 32'h80011234, 32'h0, 32'h80011234));
        applyStimulus(mk(1, 0, 1, 5'd7,  2'b01, 2'b11, 1, 32'h0, 32'h80011234, 32'h0, 32'h80011234));
        applyStimulus(mk(1, 0, 1, 5'd8,  2'b00, 2'b00, 0, 32'h0, 32'hDEADBEEF, 32'h1234, 32'h1234));
        applyStimulus(mk(1, 0, 1, 5'd9,  2'b10, 2'b00, 0, 32'h100, 32'h0, 32'h5555, 32'h104));
        applyStimulus(mk(1, 0, 1, 5'd10, 2'b10, 2'b00, 0, 32'hFFFFFFFC, 32'h0, 32'h5555, 32'h0));
        applyStimulus(mk(1, 0, 1, 5'd11, 2'b11, 2'b00, 0, 32'h100, 32'h1111, 32'h2222, 32'h0));
        applyStimulus(mk(1, 0, 1, 5'd3,  2'b00, 2'b00, 0, 32'h0, 32'h0, 32'hA, 32'hA));
        applyStimulus(mk(1, 0, 1, 5'd4,  2'b00, 2'b00, 0, 32'h0, 32'h0, 32'hB, 32'hB));
        applyStimulus(mk(1, 0, 0, 5'd13, 2'b00, 2'b00, 0, 32'h0, 32'h0, 32'h77, 32'h0));
        drain();
        checkOutput("instret_after_block", instret_o, 64'd14);

        applyStimulus(mk(1, 0, 1, 5'd0,  2'b00, 2'b00, 0, 32'h0, 32'h0, 32'h55, 32'h0));
        drain();
        checkOutput("instret_rd0", instret_o, 64'd15);

        applyStimulus(mk(1, 1, 1, 5'd12, 2'b00, 2'b00, 0, 32'h0, 32'h0, 32'h66, 32'h66));
        drain();
        checkOutput("instret_flush", instret_o, 64'd15);

        // Asynchronous reset between edges with r22 sitting in the align register.
        applyStimulus(mk(1, 0, 1, 5'd21, 2'b00, 2'b00, 0, 32'h0, 32'h0, 32'h2121, 32'h2121));
        applyStimulus(mk(1, 0, 1, 5'd22, 2'b00, 2'b00, 0, 32'h0, 32'h0, 32'h2222, 32'h2222));
        @(posedge clk);
        #1;
        checkOutput("instret_before_rst", instret_o, 64'd16);
        #1;
        rst = 1;
        valid_i = 1; regWE_i = 1; rd_i = 5'd5; wbSel_i = 2'b01; data_i = 32'hFFFFFFFF;
        alu_i = 32'hFFFFFFFF;
        #1;
        checkOutput("midrst_regWE", regWE_o, 0);
        checkOutput("midrst_rd", rd_o, 0);
        checkOutput("midrst_wbData", wbData_o, 0);
        checkOutput("midrst_fwd1V", fwd1V_o, 0);
        checkOutput("midrst_fwd2V", fwd2V_o, 0);
        checkOutput("midrst_instret", instret_o, 0);
        expQ.delete();
        pendData = 32'h0;
        pendAlu  = 32'h0;
        @(posedge clk);
        #2;
        checkOutput("rst_hold_regWE", regWE_o, 0);
        checkOutput("rst_hold_wbData", wbData_o, 0);
        setBubble();
        #1;
        rst = 0;

        applyStimulus(mk(1, 0, 1, 5'd20, 2'b00, 2'b00, 0, 32'h0, 32'h0, 32'hCAFE, 32'hCAFE));
        for (int i = 0; i < 14; i++)
            applyStimulus(mk(1, 0, 0, 5'd1, 2'b00, 2'b00, 0, 32'h0, 32'h0, 32'h0, 32'h0));
        drain();
        checkOutput("instret_15", instret_o, 64'd15);
        checkOutput("small_instret_allones", smInstret, 4'hF);

        applyStimulus(mk(1, 0, 0, 5'd1, 2'b00, 2'b00, 0, 32'h0, 32'h0, 32'h0, 32'h0));
        drain();
        checkOutput("instret_16", instret_o, 64'd16);
        checkOutput("small_instret_wrap", smInstret, 4'h0);

        checkOutput("queue_empty", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
